// File: rtl/opcodes.sv
// opcodes: instruction opcodes, ALU functions and PC-select encodings
// shared by the control sequencer and the datapath.
package opcodes;

  typedef enum logic [3:0] {
    NOOP, STSW, LEDS, STACC, PASSA, ADD, LUI, ADDI,
    JMP, JMPA, JMPI, MULT, WAIT0, WAIT1
  } opcodes_t;

  typedef enum logic [1:0] {
    ALU_NOOP, ALU_A, ALU_ADD, ALU_MULT
  } alu_functions_t;

  typedef enum logic [1:0] {
    PcInc, PcWait, PcJmp
  } PcSel_t;

endpackage

// File: rtl/control_fsm_if.sv
// control_fsm_if: opcode/switch inputs and datapath control outputs of control_fsm.
// The slave modport is the sequencer side, master is the instruction/datapath side.
interface control_fsm_if #(
  parameter int NSW = 8
);
  import opcodes::*;

  localparam int SelW = (NSW > 1) ? $clog2(NSW) : 1;

  opcodes_t       OpCode;
  logic [SelW-1:0] SwSel;
  logic [NSW-1:0] Sw;

  logic           RegWe;
  logic           WDataSel;
  logic           AccStore;
  logic           LedStore;
  logic           Op1Sel;
  logic           Op2Sel;
  logic           ImmSel;
  alu_functions_t AluOp;
  PcSel_t         PcSel;
  logic           Stall;
  logic           WaitTimeout;

  modport master (
    output OpCode, SwSel, Sw,
    input  RegWe, WDataSel, AccStore, LedStore, Op1Sel, Op2Sel, ImmSel,
           AluOp, PcSel, Stall, WaitTimeout
  );

  modport slave (
    input  OpCode, SwSel, Sw,
    output RegWe, WDataSel, AccStore, LedStore, Op1Sel, Op2Sel, ImmSel,
           AluOp, PcSel, Stall, WaitTimeout
  );

endinterface

// File: rtl/control_fsm.sv
// control_fsm: sequential control decoder with multi-cycle MULT, post-jump flush and
// WAIT on a synchronised switch. Define CONTROL_WAIT_TIMEOUT_EN to bound WAIT by WAIT_TIMEOUT.
module control_fsm
  import opcodes::*;
#(
  parameter int NSW          = 8,
  parameter int SYNC_STAGES  = 2,
  parameter int MULT_CYCLES  = 3,
  parameter int FLUSH_JMP    = 1
`ifdef CONTROL_WAIT_TIMEOUT_EN
  ,
  parameter int WAIT_TIMEOUT = 255
`endif
) (
  input logic          Clock,
  input logic          Reset,
  control_fsm_if.slave bus
);

  typedef enum logic [1:0] {S_EXEC, S_WAIT, S_MULT, S_FLUSH} state_t;

  localparam int              CntW     = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;
  localparam logic [CntW-1:0] MultLast = CntW'(MULT_CYCLES - 1);
  localparam int              SelW     = (NSW > 1) ? $clog2(NSW) : 1;

  state_t          state, stateNext;
  logic [CntW-1:0] cnt, cntNext;
  logic [SelW-1:0] waitSel, waitSelNext;
  logic            waitPol, waitPolNext;   // switch level that keeps the WAIT stalled
  logic [NSW-1:0]  syncQ [SYNC_STAGES];
  logic [NSW-1:0]  swS;

`ifdef CONTROL_WAIT_TIMEOUT_EN
  localparam int            TW       = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
  localparam logic [TW-1:0] TcntLast = TW'(WAIT_TIMEOUT - 1);
  logic [TW-1:0] tcnt, tcntNext;
`endif

  // NOTE: the synchroniser is a flop chain, not a RAM, so it takes a reset like any other
  // state; a clean 0 after reset keeps WAIT decisions deterministic.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) syncQ[i] <= '0;
    end else begin
      syncQ[0] <= bus.Sw;
      for (int i = 1; i < SYNC_STAGES; i++) syncQ[i] <= syncQ[i-1];
    end
  end

  assign swS = syncQ[SYNC_STAGES-1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= S_EXEC;
      cnt     <= '0;
      waitSel <= '0;
      waitPol <= 1'b0;
`ifdef CONTROL_WAIT_TIMEOUT_EN
      tcnt    <= '0;
`endif
    end else begin
      state   <= stateNext;
      cnt     <= cntNext;
      waitSel <= waitSelNext;
      waitPol <= waitPolNext;
`ifdef CONTROL_WAIT_TIMEOUT_EN
      tcnt    <= tcntNext;
`endif
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    stateNext    = state;
    cntNext      = cnt;
    waitSelNext  = waitSel;
    waitPolNext  = waitPol;
`ifdef CONTROL_WAIT_TIMEOUT_EN
    tcntNext        = tcnt;
    bus.WaitTimeout = 1'b0;
`endif
    bus.RegWe    = 1'b0;
    bus.WDataSel = 1'b0;
    bus.AccStore = 1'b0;
    bus.LedStore = 1'b0;
    bus.Op1Sel   = 1'b0;
    bus.Op2Sel   = 1'b0;
    bus.ImmSel   = 1'b0;
    bus.AluOp    = ALU_NOOP;
    bus.PcSel    = PcInc;

    // Reset holds every output at its default, which also squashes an in-flight MULT store.
    if (!Reset) begin
      unique case (state)
        S_EXEC: begin
          case (bus.OpCode)
            STSW:  begin bus.WDataSel = 1'b1; bus.RegWe = 1'b1; end
            LEDS:  bus.LedStore = 1'b1;
            STACC: bus.RegWe = 1'b1;
            PASSA: begin bus.AluOp = ALU_A;   bus.AccStore = 1'b1; end
            ADD:   begin bus.AluOp = ALU_ADD; bus.AccStore = 1'b1; end
            LUI: begin
              bus.Op1Sel   = 1'b1;
              bus.ImmSel   = 1'b1;
              bus.AluOp    = ALU_A;
              bus.AccStore = 1'b1;
            end
            ADDI: begin
              bus.Op1Sel   = 1'b1;
              bus.AluOp    = ALU_ADD;
              bus.AccStore = 1'b1;
            end
            JMP, JMPA, JMPI: begin
              bus.Op1Sel = (bus.OpCode != JMP);
              bus.Op2Sel = (bus.OpCode != JMPA);
              bus.AluOp  = ALU_ADD;
              bus.PcSel  = PcJmp;
              stateNext  = (FLUSH_JMP != 0) ? S_FLUSH : S_EXEC;
            end
            MULT: begin
              bus.AluOp = ALU_MULT;
              if (MULT_CYCLES == 1) begin
                bus.AccStore = 1'b1;
              end else begin
                bus.PcSel = PcWait;
                cntNext   = CntW'(1);
                stateNext = S_MULT;
              end
            end
            WAIT0, WAIT1: begin
              if (swS[bus.SwSel] == (bus.OpCode == WAIT1)) begin
                bus.PcSel   = PcWait;
                waitSelNext = bus.SwSel;
                waitPolNext = (bus.OpCode == WAIT1);
`ifdef CONTROL_WAIT_TIMEOUT_EN
                tcntNext    = '0;
`endif
                stateNext   = S_WAIT;
              end
            end
            default: ;
          endcase
        end

        S_MULT: begin
          bus.AluOp = ALU_MULT;
          if (cnt == MultLast) begin
            bus.AccStore = 1'b1;
            stateNext    = S_EXEC;
          end else begin
            bus.PcSel = PcWait;
            cntNext   = cnt + 1'b1;
          end
        end

        S_WAIT: begin
          if (swS[waitSel] == waitPol) begin
`ifdef CONTROL_WAIT_TIMEOUT_EN
            if (tcnt == TcntLast) begin
              bus.WaitTimeout = 1'b1;
              stateNext       = S_EXEC;
            end else begin
              bus.PcSel = PcWait;
              tcntNext  = tcnt + 1'b1;
            end
`else
            bus.PcSel = PcWait;
`endif
          end else begin
            stateNext = S_EXEC;
          end
        end

        S_FLUSH: stateNext = S_EXEC;
      endcase
    end
  end

  assign bus.Stall = (bus.PcSel == PcWait);

`ifndef CONTROL_WAIT_TIMEOUT_EN
  assign bus.WaitTimeout = 1'b0;
`endif

endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: scoreboard bench for control_fsm; each scenario task queues the expected
// control vector as it drives a cycle and compares it at the falling edge.
module tb_control_fsm;
  import opcodes::*;

  localparam int MC = 3;
  localparam int SS = 2;
`ifdef CONTROL_WAIT_TIMEOUT_EN
  localparam int TO = 4;
`endif

  typedef struct packed {
    logic           regWe, wDataSel, accStore, ledStore, op1Sel, op2Sel, immSel;
    alu_functions_t aluOp;
    PcSel_t         pcSel;
    logic           stall, waitTimeout;
  } ctl_t;

  typedef struct {
    logic       rst;
    opcodes_t   op;
    logic [2:0] sel;
    logic [7:0] sw;
    ctl_t       exp;
  } stim_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  control_fsm_if #(.NSW(8)) bus ();

  control_fsm #(
    .NSW(8),
    .SYNC_STAGES(SS),
    .MULT_CYCLES(MC),
    .FLUSH_JMP(1)
`ifdef CONTROL_WAIT_TIMEOUT_EN
    ,
    .WAIT_TIMEOUT(TO)
`endif
  ) dut (
    .Clock(clk),
    .Reset(rst),
    .bus(bus.slave)
  );

  ctl_t expQ[$];
  int   errors = 0;
  int   checks = 0;

  function automatic ctl_t dflt();
    ctl_t c;
    c       = '0;
    c.aluOp = ALU_NOOP;
    c.pcSel = PcInc;
    return c;
  endfunction

  function automatic ctl_t stallExp(alu_functions_t fn);
    ctl_t c;
    c       = dflt();
    c.aluOp = fn;
    c.pcSel = PcWait;
    c.stall = 1'b1;
    return c;
  endfunction

  function automatic stim_t st(logic r, opcodes_t op, logic [2:0] sel, logic [7:0] sw, ctl_t e);
    stim_t s;
    s.rst = r; s.op = op; s.sel = sel; s.sw = sw; s.exp = e;
    return s;
  endfunction

  function automatic ctl_t observe();
    ctl_t c;
    c.regWe       = bus.RegWe;
    c.wDataSel    = bus.WDataSel;
    c.accStore    = bus.AccStore;
    c.ledStore    = bus.LedStore;
    c.op1Sel      = bus.Op1Sel;
    c.op2Sel      = bus.Op2Sel;
    c.immSel      = bus.ImmSel;
    c.aluOp       = bus.AluOp;
    c.pcSel       = bus.PcSel;
    c.stall       = bus.Stall;
    c.waitTimeout = bus.WaitTimeout;
    return c;
  endfunction

  // Applies one cycle of stimulus and queues the control vector that cycle must produce.
  task automatic drive(stim_t s);
    rst        = s.rst;
    bus.OpCode = s.op;
    bus.SwSel  = s.sel;
    bus.Sw     = s.sw;
    expQ.push_back(s.exp);
  endtask

  task automatic test_reset();
    stim_t seq[$];
    ctl_t  got, e, x;
    seq.push_back(st(1'b1, ADD, 3'd0, 8'h00, dflt()));
    seq.push_back(st(1'b1, ADD, 3'd0, 8'h00, dflt()));
    x = dflt(); x.aluOp = ALU_ADD; x.accStore = 1'b1;
    seq.push_back(st(1'b0, ADD, 3'd0, 8'h00, x));
    foreach (seq[i]) begin
      drive(seq[i]);
      @(negedge clk);
      got = observe(); e = expQ.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset[%0d] got=%h exp=%h", i, got, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_decode();
    stim_t      seq[$];
    ctl_t       got, e, x;
    opcodes_t   ops[10] = '{NOOP, STSW, LEDS, STACC, PASSA, ADD, LUI, ADDI, WAIT0, WAIT1};
    logic [7:0] sw = 8'h01;   // Sw[0]=1 releases WAIT0 on switch 0, Sw[1]=0 releases WAIT1 on switch 1
    for (int i = 0; i < SS; i++) seq.push_back(st(1'b0, NOOP, 3'd0, sw, dflt()));
    foreach (ops[i]) begin
      x = dflt();
      case (ops[i])
        STSW:  begin x.wDataSel = 1'b1; x.regWe = 1'b1; end
        LEDS:  x.ledStore = 1'b1;
        STACC: x.regWe = 1'b1;
        PASSA: begin x.aluOp = ALU_A; x.accStore = 1'b1; end
        ADD:   begin x.aluOp = ALU_ADD; x.accStore = 1'b1; end
        LUI:   begin x.op1Sel = 1'b1; x.immSel = 1'b1; x.aluOp = ALU_A; x.accStore = 1'b1; end
        ADDI:  begin x.op1Sel = 1'b1; x.aluOp = ALU_ADD; x.accStore = 1'b1; end
        default: ;
      endcase
      seq.push_back(st(1'b0, ops[i], (ops[i] == WAIT1) ? 3'd1 : 3'd0, sw, x));
    end
    foreach (seq[i]) begin
      drive(seq[i]);
      @(negedge clk);
      got = observe(); e = expQ.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL decode[%0d] op=%s got=%h exp=%h", i, seq[i].op.name(), got, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_jump();
    stim_t    seq[$];
    ctl_t     got, e, x, st1;
    opcodes_t jops[3] = '{JMP, JMPA, JMPI};
    st1 = dflt(); st1.wDataSel = 1'b1; st1.regWe = 1'b1;
    foreach (jops[i]) begin
      x = dflt(); x.aluOp = ALU_ADD; x.pcSel = PcJmp;
      x.op1Sel = (jops[i] == JMPA) || (jops[i] == JMPI);
      x.op2Sel = (jops[i] == JMP)  || (jops[i] == JMPI);
      seq.push_back(st(1'b0, jops[i], 3'd0, 8'h00, x));
      seq.push_back(st(1'b0, STSW, 3'd0, 8'h00, dflt()));   // squashed by the flush bubble
      seq.push_back(st(1'b0, STSW, 3'd0, 8'h00, st1));
    end
    // A jump sitting in the flush slot must itself be squashed.
    x = dflt(); x.aluOp = ALU_ADD; x.pcSel = PcJmp; x.op2Sel = 1'b1;
    seq.push_back(st(1'b0, JMP, 3'd0, 8'h00, x));
    seq.push_back(st(1'b0, JMPA, 3'd0, 8'h00, dflt()));
    foreach (seq[i]) begin
      drive(seq[i]);
      @(negedge clk);
      got = observe(); e = expQ.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL jump[%0d] op=%s got=%h exp=%h", i, seq[i].op.name(), got, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mult();
    stim_t seq[$];
    ctl_t  got, e, done, addE;
    done = dflt(); done.aluOp = ALU_MULT; done.accStore = 1'b1;
    addE = dflt(); addE.aluOp = ALU_ADD;  addE.accStore = 1'b1;
    // Two MULTs back to back; the following opcode is ignored until the last cycle.
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < MC; k++)
        seq.push_back(st(1'b0, (k == 0) ? MULT : ADD, 3'd0, 8'h00,
                         (k < MC - 1) ? stallExp(ALU_MULT) : done));
    seq.push_back(st(1'b0, ADD, 3'd0, 8'h00, addE));
    // Reset in the second MULT cycle aborts it: no store afterwards.
    seq.push_back(st(1'b0, MULT, 3'd0, 8'h00, stallExp(ALU_MULT)));
    seq.push_back(st(1'b1, MULT, 3'd0, 8'h00, dflt()));
    seq.push_back(st(1'b0, NOOP, 3'd0, 8'h00, dflt()));
    seq.push_back(st(1'b0, NOOP, 3'd0, 8'h00, dflt()));
    foreach (seq[i]) begin
      drive(seq[i]);
      @(negedge clk);
      got = observe(); e = expQ.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL mult[%0d] got=%h exp=%h", i, got, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wait();
    stim_t seq[$];
    ctl_t  got, e;
    for (int i = 0; i < SS; i++) seq.push_back(st(1'b0, NOOP, 3'd5, 8'h20, dflt()));
    seq.push_back(st(1'b0, WAIT1, 3'd5, 8'h20, stallExp(ALU_NOOP)));
    // SwSel now points at a low switch and Sw[4] toggles: the latched switch 5 must still rule.
    seq.push_back(st(1'b0, WAIT1, 3'd0, 8'h30, stallExp(ALU_NOOP)));
    seq.push_back(st(1'b0, WAIT1, 3'd0, 8'h00, stallExp(ALU_NOOP)));   // Sw[5] falls here
    seq.push_back(st(1'b0, WAIT1, 3'd0, 8'h10, stallExp(ALU_NOOP)));
    seq.push_back(st(1'b0, WAIT1, 3'd0, 8'h10, dflt()));               // SYNC_STAGES edges later
    seq.push_back(st(1'b0, NOOP,  3'd0, 8'h10, dflt()));
    foreach (seq[i]) begin
      drive(seq[i]);
      @(negedge clk);
      got = observe(); e = expQ.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL wait[%0d] got=%h exp=%h", i, got, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    stim_t seq[$];
    ctl_t  got, e, x;
    for (int i = 0; i < SS; i++) seq.push_back(st(1'b0, NOOP, 3'd2, 8'h00, dflt()));
`ifdef CONTROL_WAIT_TIMEOUT_EN
    seq.push_back(st(1'b0, WAIT0, 3'd2, 8'h00, stallExp(ALU_NOOP)));
    for (int k = 0; k < TO - 1; k++) seq.push_back(st(1'b0, WAIT0, 3'd2, 8'h00, stallExp(ALU_NOOP)));
    x = dflt(); x.waitTimeout = 1'b1;
    seq.push_back(st(1'b0, WAIT0, 3'd2, 8'h00, x));
`else
    // Without the timeout a WAIT holds for as long as the switch stays low.
    seq.push_back(st(1'b0, WAIT0, 3'd2, 8'h00, stallExp(ALU_NOOP)));
    for (int k = 0; k < 20; k++) seq.push_back(st(1'b0, WAIT0, 3'd2, 8'h00, stallExp(ALU_NOOP)));
    for (int k = 0; k < SS; k++) seq.push_back(st(1'b0, WAIT0, 3'd2, 8'h04, stallExp(ALU_NOOP)));
    x = dflt();
    seq.push_back(st(1'b0, WAIT0, 3'd2, 8'h04, x));
`endif
    seq.push_back(st(1'b0, NOOP, 3'd2, 8'h00, dflt()));
    foreach (seq[i]) begin
      drive(seq[i]);
      @(negedge clk);
      got = observe(); e = expQ.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL timeout[%0d] got=%h exp=%h", i, got, e);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst        = 1'b1;
    bus.OpCode = NOOP;
    bus.SwSel  = '0;
    bus.Sw     = '0;
    @(posedge clk); #1;
    test_reset();
    test_decode();
    test_jump();
    test_mult();
    test_wait();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
